rgb_fade_sequencer: RTL and testbench
=====================================

Name: rgb_fade_sequencer

Overview:
Avalon-MM slave that sits directly upstream of the RGB PWM controller and drives its three duty-cycle inputs. Software writes target colour and step period, then issues start. The block ramps each channel's duty one LSB per step toward its target, giving hardware colour fades without CPU polling. It signals completion with a sticky status bit and a one-cycle fade_done pulse.

Parameters:
DUTY_W, 12, width of each duty-cycle word; matches the PWM controller duty input.
PERIOD_W, 24, width of the step-period register in clk cycles.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
avs_address  in  4  word register address
avs_read  in  1  Avalon read strobe
avs_write  in  1  Avalon write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered, 1-cycle latency
duty_red  out  DUTY_W  current red duty to PWM controller
duty_green  out  DUTY_W  current green duty
duty_blue  out  DUTY_W  current blue duty
busy  out  1  high while the FSM is in FADE
fade_done  out  1  one-cycle pulse when a fade completes

Behaviour:
- Single clock domain. rst is asynchronous, active-high.
- Reset values: duty_* = 0, targets = 0, period = 0, shadow targets = 0, step counter = 0, state = IDLE, busy = 0, fade_done = 0, done_sticky = 0, avs_readdata = 0.
- Register map:
  - 0/1/2 target R/G/B (RW, low DUTY_W bits; upper bits ignored, read as 0).
  - 3 step_period (RW, low PERIOD_W bits).
  - 4 control (WO): bit0 start, bit1 abort; self-clearing; reads 0.
  - 5 status (RO except W1C): bit0 busy, bit1 done_sticky; writing 1 to bit1 clears it.
  - 6/7/8 current R/G/B (RO).
  - All other addresses read 0; writes to them are ignored.
- Reads: avs_readdata is valid on the cycle after avs_read. There are no wait states.
- FSM has two states, IDLE and FADE.
  - Start accepted at edge N, period P > 0: target registers are copied into the shadow targets, the counter is loaded with P-1, and the state moves to FADE (busy=1 from edge N).
  - In FADE the counter decrements each cycle. When it is 0, a tick occurs: each channel whose duty differs from its shadow target moves ±1 toward it, and the counter reloads P-1. Ticks therefore fall at edges N+P, N+2P, ...
  - When the tick leaves all three channels equal to their shadow targets, on that same edge: state moves to IDLE, busy=0, done_sticky=1, and fade_done=1 for exactly one cycle.
- Start with P = 0: all duty_* are loaded with the targets at edge N. done_sticky and fade_done are set at the same edge, and the state stays IDLE.
- Start when the targets already equal the current duties: completes at edge N as above, with no ticks.
- Start during FADE (retarget): the shadow targets are re-latched, the counter reloads P-1, and ramping continues from the current duties. No fade_done is produced for the interrupted fade.
- Abort: the state moves to IDLE at that edge and duty_* hold their values. done_sticky is unchanged and there is no fade_done pulse.
- Start and abort in the same write: abort wins.
- Writes to target or period registers during FADE update the registers only. The active fade uses the shadow targets and the period latched at start.
- Duty arithmetic never wraps; a channel stops exactly at its target.
- W1C of done_sticky on the same edge as completion: the set wins.

Decomposition:
- Package rgb_fade_pkg holds:
  - register address constants (ADDR_TGT_R…ADDR_CUR_B);
  - control/status bit indices;
  - the state enum {IDLE, FADE};
  - the default DUTY_W.
- Sub-module fade_channel, instantiated 3×:
  - inputs: clk, rst, tick, load_now, target;
  - outputs: duty, at_target;
  - behaviour: saturating ±1 step toward target on tick, direct load on load_now.

Test Plan:
- Reset mid-fade (red ramping 0→100, P=5, assert rst at cycle 37) -> all duty_*=0, busy=0, status read=0, target reads 0.
- Targets R=4, G=0, B=2, P=10, start at edge N -> duty_red steps 1,2,3,4 at N+10/20/30/40; duty_blue reaches 2 at N+20 and holds; fade_done high one cycle after N+40; status=0b10.
- Ramp down: current R=3, target R=0, P=1 -> duty_red 2,1,0 on consecutive edges; fade_done after the third tick; no underflow past 0.
- P=0, target G=0xFFF, start -> duty_green=0xFFF one edge after start; busy never asserts; fade_done pulses once.
- Mid-fade retarget: R ramping 0→50, P=2; at duty_red=10 write target 5 and start -> ramps down 9…5; exactly one fade_done at the end.
- Start+abort in the same write, and abort mid-fade at duty_red=7 -> busy=0, duty_red holds 7, no fade_done, done_sticky unchanged; W1C to status bit1 clears it.

Source files
------------

// File: rtl/rgb_fade_pkg.sv
// Shared register map, bit positions and FSM state type for the RGB fade sequencer.
package rgb_fade_pkg;
  localparam int DUTY_W_DEF   = 12;
  localparam int PERIOD_W_DEF = 24;

  localparam logic [3:0] ADDR_TGT_R  = 4'd0;
  localparam logic [3:0] ADDR_TGT_G  = 4'd1;
  localparam logic [3:0] ADDR_TGT_B  = 4'd2;
  localparam logic [3:0] ADDR_PERIOD = 4'd3;
  localparam logic [3:0] ADDR_CTRL   = 4'd4;
  localparam logic [3:0] ADDR_STATUS = 4'd5;
  localparam logic [3:0] ADDR_CUR_R  = 4'd6;
  localparam logic [3:0] ADDR_CUR_G  = 4'd7;
  localparam logic [3:0] ADDR_CUR_B  = 4'd8;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  typedef enum logic {IDLE = 1'b0, FADE = 1'b1} fade_state_e;
endpackage

// File: rtl/rgb_fade_sequencer_channel.sv
// One colour channel: holds the live duty and walks it one LSB per tick toward its target.
module fade_channel #(
  parameter int DUTY_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load_now,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] duty,
  output logic              at_target
);
  logic [DUTY_W-1:0] duty_q, duty_d;

  // Stepping only toward the target means the value can never wrap.
  always_comb begin
    duty_d = duty_q;
    if (load_now) begin
      duty_d = target;
    end else if (tick) begin
      if (duty_q < target) begin
        duty_d = duty_q + DUTY_W'(1);
      end else if (duty_q > target) begin
        duty_d = duty_q - DUTY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty = duty_q;
  // Looks at the post-edge value so the top can finish on the same edge as the last step.
  assign at_target = (duty_d == target);
endmodule

// File: rtl/rgb_fade_sequencer.sv
// Avalon-MM fade sequencer ramping three PWM duty words toward software targets.
// state | meaning
// IDLE  | duties static, waiting for start
// FADE  | step counter running, channels step on each terminal count
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [DUTY_W-1:0] duty_red,
  output logic [DUTY_W-1:0] duty_green,
  output logic [DUTY_W-1:0] duty_blue,
  output logic              busy,
  output logic              fade_done
);
  fade_state_e state_q, state_d;

  logic [2:0][DUTY_W-1:0] tgt_q, tgt_d, shadow_q, shadow_d, ch_target, duty;
  logic [PERIOD_W-1:0]    period_q, period_d, per_sh_q, per_sh_d, cnt_q, cnt_d;
  logic                   done_sticky_q, done_sticky_d, fade_done_q, fade_done_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [2:0]             at_tgt;
  logic                   ctrl_wr, start_req, abort_req, load_now, tick, complete;
  logic                   wdata_unused;

  assign ctrl_wr   = avs_write && (avs_address == ADDR_CTRL);
  assign abort_req = ctrl_wr && avs_writedata[CTRL_ABORT];
  assign start_req = ctrl_wr && avs_writedata[CTRL_START] && !avs_writedata[CTRL_ABORT];
  assign load_now  = start_req && (period_q == '0);
  // A start or abort owns the edge; the step counter only ticks on an otherwise quiet cycle.
  assign tick      = (state_q == FADE) && !start_req && !abort_req && (cnt_q == '0);
  assign ch_target = start_req ? tgt_q : shadow_q;
  assign complete  = (start_req || tick) && (&at_tgt);
  assign wdata_unused = ^avs_writedata[31:PERIOD_W];

  for (genvar g = 0; g < 3; g++) begin : g_ch
    fade_channel #(.DUTY_W(DUTY_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .load_now  (load_now),
      .target    (ch_target[g]),
      .duty      (duty[g]),
      .at_target (at_tgt[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_req || complete) begin
      state_d = IDLE;
    end else if (start_req) begin
      state_d = FADE;
    end
  end

  always_comb begin
    busy      = (state_q == FADE);
    fade_done = fade_done_q;
  end

  always_comb begin
    tgt_d         = tgt_q;
    period_d      = period_q;
    done_sticky_d = done_sticky_q;
    shadow_d      = start_req ? tgt_q : shadow_q;
    per_sh_d      = start_req ? period_q : per_sh_q;
    cnt_d         = cnt_q;
    if (start_req) begin
      cnt_d = period_q - PERIOD_W'(1);
    end else if (state_q == FADE) begin
      cnt_d = (cnt_q == '0) ? per_sh_q - PERIOD_W'(1) : cnt_q - PERIOD_W'(1);
    end
    if (avs_write) begin
      case (avs_address)
        ADDR_TGT_R:  tgt_d[0] = avs_writedata[DUTY_W-1:0];
        ADDR_TGT_G:  tgt_d[1] = avs_writedata[DUTY_W-1:0];
        ADDR_TGT_B:  tgt_d[2] = avs_writedata[DUTY_W-1:0];
        ADDR_PERIOD: period_d = avs_writedata[PERIOD_W-1:0];
        ADDR_STATUS: if (avs_writedata[STAT_DONE]) done_sticky_d = 1'b0;
        default: ;
      endcase
    end
    // Completion beats a same-edge W1C clear.
    if (complete) begin
      done_sticky_d = 1'b1;
    end
    fade_done_d = complete;
  end

  always_comb begin
    rdata_d = '0;
    if (avs_read) begin
      case (avs_address)
        ADDR_TGT_R:  rdata_d = 32'(tgt_q[0]);
        ADDR_TGT_G:  rdata_d = 32'(tgt_q[1]);
        ADDR_TGT_B:  rdata_d = 32'(tgt_q[2]);
        ADDR_PERIOD: rdata_d = 32'(period_q);
        ADDR_STATUS: begin
          rdata_d[STAT_BUSY] = busy;
          rdata_d[STAT_DONE] = done_sticky_q;
        end
        ADDR_CUR_R:  rdata_d = 32'(duty[0]);
        ADDR_CUR_G:  rdata_d = 32'(duty[1]);
        ADDR_CUR_B:  rdata_d = 32'(duty[2]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q         <= '0;
      shadow_q      <= '0;
      period_q      <= '0;
      per_sh_q      <= '0;
      cnt_q         <= '0;
      done_sticky_q <= 1'b0;
      fade_done_q   <= 1'b0;
      rdata_q       <= '0;
    end else begin
      tgt_q         <= tgt_d;
      shadow_q      <= shadow_d;
      period_q      <= period_d;
      per_sh_q      <= per_sh_d;
      cnt_q         <= cnt_d;
      done_sticky_q <= done_sticky_d;
      fade_done_q   <= fade_done_d;
      rdata_q       <= rdata_d;
    end
  end

  assign duty_red     = duty[0];
  assign duty_green   = duty[1];
  assign duty_blue    = duty[2];
  assign avs_readdata = rdata_q;
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer: register-map vector table plus fade sequences.
module tb_rgb_fade_sequencer;
  import rgb_fade_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic [11:0] duty_red, duty_green, duty_blue;
  logic        busy, fade_done;

  int checks   = 0;
  int failures = 0;

  rgb_fade_sequencer #(.DUTY_W(12), .PERIOD_W(24)) dut (
    .clk           (clk),
    .rst           (rst),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .duty_red      (duty_red),
    .duty_green    (duty_green),
    .duty_blue     (duty_blue),
    .busy          (busy),
    .fade_done     (fade_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; avs_writedata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  logic [31:0] rv;
  int          dcount, bad;
  logic        found;
  int          er, eb;

  initial begin
    rst = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    vecs[0] = '{1'b1, ADDR_TGT_R,  32'hFFFF_FABC, 32'h0000_0ABC};
    vecs[1] = '{1'b1, ADDR_TGT_G,  32'h0000_0123, 32'h0000_0123};
    vecs[2] = '{1'b1, ADDR_TGT_B,  32'h8000_0FFF, 32'h0000_0FFF};
    vecs[3] = '{1'b1, ADDR_PERIOD, 32'hFF12_3456, 32'h0012_3456};
    vecs[4] = '{1'b1, ADDR_CTRL,   32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{1'b1, ADDR_STATUS, 32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{1'b0, ADDR_CUR_R,  32'h0,         32'h0000_0000};
    vecs[7] = '{1'b1, 4'd9,        32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{1'b0, 4'd15,       32'h0,         32'h0000_0000};
    vecs[9] = '{1'b0, ADDR_CUR_B,  32'h0,         32'h0000_0000};

    step(3);
    check("rst_duty_r", duty_red, 0);
    check("rst_duty_g", duty_green, 0);
    check("rst_duty_b", duty_blue, 0);
    check("rst_busy", busy, 0);
    check("rst_done", fade_done, 0);
    check("rst_rdata", avs_readdata, 0);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, rv);
      check($sformatf("regvec%0d", i), rv, vecs[i].exp);
    end
    check("regvec_no_start", busy, 0);

    // Ramp up: R=4, G=0, B=2, P=10
    wr(ADDR_TGT_R, 4); wr(ADDR_TGT_G, 0); wr(ADDR_TGT_B, 2); wr(ADDR_PERIOD, 10);
    wr(ADDR_CTRL, 1);
    check("up_busy_k0", busy, 1);
    bad = 0;
    for (int k = 1; k <= 41; k++) begin
      step(1);
      er = (k / 10 > 4) ? 4 : k / 10;
      eb = (k / 10 > 2) ? 2 : k / 10;
      check($sformatf("up_r_k%0d", k), duty_red, er);
      check($sformatf("up_b_k%0d", k), duty_blue, eb);
      check($sformatf("up_done_k%0d", k), fade_done, (k == 40) ? 1 : 0);
      check($sformatf("up_busy_k%0d", k), busy, (k < 40) ? 1 : 0);
      if (duty_green != 0) bad++;
    end
    check("up_green_flat", bad, 0);
    rd(ADDR_STATUS, rv);
    check("up_status", rv, 32'h2);

    // Preload R=3 via P=0, clear sticky, then ramp down with P=1
    wr(ADDR_TGT_R, 3); wr(ADDR_TGT_B, 0); wr(ADDR_PERIOD, 0);
    wr(ADDR_CTRL, 1);
    check("p0_load_r", duty_red, 3);
    check("p0_load_b", duty_blue, 0);
    check("p0_load_done", fade_done, 1);
    check("p0_load_busy", busy, 0);
    wr(ADDR_STATUS, 2);
    rd(ADDR_STATUS, rv);
    check("w1c_clear", rv, 0);
    wr(ADDR_TGT_R, 0); wr(ADDR_PERIOD, 1);
    wr(ADDR_CTRL, 1);
    check("dn_busy_k0", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check($sformatf("dn_r_k%0d", k), duty_red, (k >= 3) ? 0 : 3 - k);
      check($sformatf("dn_done_k%0d", k), fade_done, (k == 3) ? 1 : 0);
      check($sformatf("dn_busy_k%0d", k), busy, (k < 3) ? 1 : 0);
    end

    // P=0 jump of green to full scale
    wr(ADDR_TGT_G, 12'hFFF); wr(ADDR_PERIOD, 0);
    wr(ADDR_CTRL, 1);
    check("p0_g", duty_green, 12'hFFF);
    check("p0_g_busy", busy, 0);
    check("p0_g_done", fade_done, 1);
    dcount = 0; bad = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (fade_done) dcount++;
      if (busy) bad++;
    end
    check("p0_g_single_pulse", dcount, 0);
    check("p0_g_never_busy", bad, 0);

    // Retarget mid-fade: R 0->50 at P=2, at R=10 retarget to 5
    wr(ADDR_TGT_R, 50); wr(ADDR_PERIOD, 2);
    wr(ADDR_CTRL, 1);
    found = 1'b0; dcount = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (fade_done) dcount++;
      if (duty_red == 10) found = 1'b1;
    end
    check("rt_reach10", found, 1);
    wr(ADDR_TGT_R, 5);
    if (fade_done) dcount++;
    wr(ADDR_CTRL, 1);
    if (fade_done) dcount++;
    check("rt_no_early_done", dcount, 0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check($sformatf("rt_r_k%0d", k), duty_red, (k >= 10) ? 5 : 10 - k / 2);
      check($sformatf("rt_done_k%0d", k), fade_done, (k == 10) ? 1 : 0);
    end
    check("rt_green_hold", duty_green, 12'hFFF);

    // Start+abort together, then abort mid-fade at R=7
    wr(ADDR_TGT_R, 20); wr(ADDR_PERIOD, 4);
    wr(ADDR_CTRL, 3);
    check("sa_busy", busy, 0);
    check("sa_done", fade_done, 0);
    step(5);
    check("sa_r_hold", duty_red, 5);
    check("sa_busy_later", busy, 0);
    wr(ADDR_CTRL, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (duty_red == 7) found = 1'b1;
    end
    check("ab_reach7", found, 1);
    wr(ADDR_CTRL, 2);
    check("ab_busy", busy, 0);
    dcount = 0; bad = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (fade_done) dcount++;
      if (duty_red != 7) bad++;
    end
    check("ab_no_done", dcount, 0);
    check("ab_r_hold7", bad, 0);
    rd(ADDR_STATUS, rv);
    check("ab_sticky_kept", rv, 32'h2);
    wr(ADDR_STATUS, 2);
    rd(ADDR_STATUS, rv);
    check("ab_w1c", rv, 0);

    // Async reset in the middle of a fade
    wr(ADDR_TGT_R, 100); wr(ADDR_PERIOD, 5);
    wr(ADDR_CTRL, 1);
    step(37);
    check("mid_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_r", duty_red, 0);
    check("mid_rst_g", duty_green, 0);
    check("mid_rst_b", duty_blue, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    rd(ADDR_STATUS, rv);
    check("mid_rst_status", rv, 0);
    rd(ADDR_TGT_R, rv);
    check("mid_rst_tgt_r", rv, 0);
    rd(ADDR_PERIOD, rv);
    check("mid_rst_period", rv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
